// File: rtl/snake_pkg.sv
// Shared definitions for the snake game's pixel path: coordinate and colour
// widths, screen limits, palette constants and the plot queue FSM encoding.
package snake_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    // One queued request is {x, y, colour}.
    localparam int PIX_W = X_W + Y_W + COL_W;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COL_W-1:0] COL_RED   = 3'b100;
    localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    function automatic pixel_t make_pixel(input logic [X_W-1:0] x,
                                          input logic [Y_W-1:0] y,
                                          input logic [COL_W-1:0] colour);
        pixel_t p;
        p.x      = x;
        p.y      = y;
        p.colour = colour;
        return p;
    endfunction

endpackage

// File: rtl/plot_request_queue_if.sv
// Producer-to-queue pixel request channel (valid/ready with x, y, colour).
// master: game logic issuing plots; slave: plot_request_queue.
interface plot_request_queue_if
    import snake_pkg::*;
    ();

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_x;
    logic [Y_W-1:0]   in_y;
    logic [COL_W-1:0] in_colour;

    modport master (
        output in_valid,
        output in_x,
        output in_y,
        output in_colour,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  in_colour,
        output in_ready
    );

endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO for queued pixel requests. Power-of-two depth so the
// pointers wrap on their own; a separate occupancy counter gives full/empty.
// Head data is presented combinationally (show-ahead).
module plot_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because count_q guards them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/plot_request_queue.sv
// Pixel plot request queue: accepts (x, y, colour) requests from game logic,
// buffers them and replays one per cycle onto the vga_adapter ports. Also
// owns the full-screen clear sweep so only this block drives the adapter.
// An empty queue in S_IDLE forwards an accepted request straight to the
// output register, so a plot appears the cycle after acceptance.
// Optional build macro: PLOT_DEDUP_EN -- drop an in-range request equal to
// the most recently stored one (snake head redraws).
module plot_request_queue
    import snake_pkg::*;
#(
    parameter int               DEPTH        = 8,
    parameter int               X_MAX        = SCREEN_W - 1,
    parameter int               Y_MAX        = SCREEN_H - 1,
    parameter logic [COL_W-1:0] CLEAR_COLOUR = COL_BLACK
) (
    input  logic                 clk,
    input  logic                 reset,
    plot_request_queue_if.slave  req,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [COL_W-1:0]     vga_colour,
    output logic                 vga_plot,
    output logic [3:0]           level,
    output logic                 oob_flag
);

    localparam int             CNT_W  = $clog2(DEPTH + 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    state_t           state_q, state_d;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic [COL_W-1:0] vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;
    logic             clear_busy_q, clear_busy_d;
    logic             oob_q;

    pixel_t           in_pix;
    pixel_t           head_pix;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             in_range;
    logic             dup;
    logic             store;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;
    logic             enter_clear;

    assign in_pix       = make_pixel(req.in_x, req.in_y, req.in_colour);
    assign req.in_ready = !fifo_full;
    assign accept       = req.in_valid && req.in_ready;
    assign in_range     = (req.in_x <= X_LAST) && (req.in_y <= Y_LAST);
    assign store        = accept && in_range && !dup;
    assign fifo_push    = store && !bypass;
    assign enter_clear  = (state_q == S_IDLE) && clear_req;

`ifdef PLOT_DEDUP_EN
    pixel_t last_q;
    logic   last_vld_q;

    assign dup = last_vld_q && (last_q == in_pix);

    // Remember the most recently stored request; forget it on a clear.
    always_ff @(posedge clk) begin
        if (reset || enter_clear) begin
            last_vld_q <= 1'b0;
            last_q     <= '0;
        end else if (store) begin
            last_vld_q <= 1'b1;
            last_q     <= in_pix;
        end
    end
`else
    assign dup = 1'b0;
`endif

    plot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (in_pix),
        .pop_i   (fifo_pop),
        .data_o  (head_pix),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next state, raster counters and the next adapter drive values.
    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        clear_busy_d = 1'b0;
        fifo_pop     = 1'b0;
        bypass       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    // Clear wins over draining; the head stays queued.
                    state_d = S_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    vga_x_d      = head_pix.x;
                    vga_y_d      = head_pix.y;
                    vga_colour_d = head_pix.colour;
                    vga_plot_d   = 1'b1;
                end else if (store) begin
                    // Empty queue: hand the request straight to the adapter.
                    bypass       = 1'b1;
                    vga_x_d      = in_pix.x;
                    vga_y_d      = in_pix.y;
                    vga_colour_d = in_pix.colour;
                    vga_plot_d   = 1'b1;
                end
            end
            S_CLEAR: begin
                vga_x_d      = cx_q;
                vga_y_d      = cy_q;
                vga_colour_d = CLEAR_COLOUR;
                vga_plot_d   = 1'b1;
                clear_busy_d = 1'b1;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, raster counters and registered adapter outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            clear_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    // Sticky out-of-range indication, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_q <= 1'b0;
        end else if (accept && !in_range) begin
            oob_q <= 1'b1;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign clear_busy = clear_busy_q;
    assign oob_flag   = oob_q;
    assign level      = 4'(fifo_count);

endmodule
